// File: rtl/decoder_3x8_seq_pkg.sv
// -----------------------------------------------------------------------------
// decoder_3x8_seq_pkg
// Shared definitions for the 3-to-8 decoder and its 8-to-3 encoder partner:
// code/data widths, FSM state encoding and the polarity-dependent idle word.
// -----------------------------------------------------------------------------
package decoder_3x8_seq_pkg;

   localparam int CODE_W = 3;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Word driven on p_data when no bit is selected (reset value).
   function automatic logic [DATA_W-1:0] idle_word(input logic active_low);
      return active_low ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
   endfunction

endpackage

// File: rtl/decoder_3x8_seq_if.sv
// -----------------------------------------------------------------------------
// decoder_3x8_seq_if
// Handshake bundle of the decoder.
//   in_valid / in_ready / p_code     : code input channel (valid/ready)
//   out_valid / out_ready / p_data   : decoded word output channel (valid/ready)
// Modports:
//   slave  : the decoder's view (consumes codes, produces words)
//   master : the environment's view (produces codes, consumes words)
// -----------------------------------------------------------------------------
interface decoder_3x8_seq_if;
   import decoder_3x8_seq_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] p_code;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] p_data;

   modport slave (
      input  in_valid, p_code, out_ready,
      output in_ready, out_valid, p_data
   );

   modport master (
      output in_valid, p_code, out_ready,
      input  in_ready, out_valid, p_data
   );

endinterface

// File: rtl/decoder_3x8_seq_onehot_dec3.sv
// -----------------------------------------------------------------------------
// onehot_dec3
// Pure combinational 3-to-8 one-hot decode with selectable output polarity.
//   code_i       : binary code
//   active_low_i : 1 = selected bit low, all others high
//   word_o       : decoded word
// -----------------------------------------------------------------------------
module onehot_dec3
   import decoder_3x8_seq_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   input  logic              active_low_i,
   output logic [DATA_W-1:0] word_o
);

   // XOR with a replicated polarity bit inverts the whole word for active-low.
   assign word_o = (DATA_W'(1) << code_i) ^ {DATA_W{active_low_i}};

endmodule

// File: rtl/decoder_3x8_seq.sv
// -----------------------------------------------------------------------------
// decoder_3x8_seq
// Registered 3-to-8 one-hot decoder with a valid/ready input, a single-entry
// valid/ready output register and a built-in walking-one scan sequencer.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : global enable, freezes acceptance and scan progress when low
//   scan_start : scan request, sampled only in IDLE
//   bus        : handshake bundle (slave view), see decoder_3x8_seq_if
//   scan_busy  : high while the sequencer is in SCAN
//   scan_done  : one-cycle pulse after the last scan word is loaded
// Parameters:
//   SCAN_DESC      : 0 = scan codes 0..7, 1 = scan codes 7..0
//   OUT_ACTIVE_LOW : 1 = p_data inverted (selected bit low)
// -----------------------------------------------------------------------------
module decoder_3x8_seq
   import decoder_3x8_seq_pkg::*;
#(
   parameter bit SCAN_DESC      = 1'b0,
   parameter bit OUT_ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               scan_start,
   decoder_3x8_seq_if.slave   bus,
   output logic               scan_busy,
   output logic               scan_done
);

   localparam logic [CODE_W-1:0] IDX_MAX   = CODE_W'(DATA_W - 1);
   localparam logic [CODE_W-1:0] IDX_FIRST = SCAN_DESC ? IDX_MAX : '0;
   localparam logic [CODE_W-1:0] IDX_LAST  = SCAN_DESC ? '0 : IDX_MAX;

   state_e              state_q;
   logic [CODE_W-1:0]   idx_q;
   logic                out_valid_q;
   logic [DATA_W-1:0]   p_data_q;
   logic                scan_busy_q;
   logic                scan_done_q;

   logic                slot_free;
   logic                in_ready_c;
   logic                in_xfer;
   logic                scan_load;
   logic [CODE_W-1:0]   dec_code;
   logic [DATA_W-1:0]   p_data_d;

   // Output slot can take a new word when empty or being drained this cycle.
   assign slot_free = !out_valid_q || bus.out_ready;

   // scan_start outranks a pending data transfer in the same cycle.
   assign in_ready_c = (state_q == ST_IDLE) && en && !scan_start && slot_free;
   assign in_xfer    = bus.in_valid && in_ready_c;
   assign scan_load  = (state_q == ST_SCAN) && en && slot_free;

   // Single decoder shared by the data path and the sequencer.
   assign dec_code = (state_q == ST_SCAN) ? idx_q : bus.p_code;

   onehot_dec3 u_dec (
      .code_i       (dec_code),
      .active_low_i (OUT_ACTIVE_LOW),
      .word_o       (p_data_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         p_data_q    <= idle_word(OUT_ACTIVE_LOW);
         scan_busy_q <= 1'b0;
         scan_done_q <= 1'b0;
      end else begin
         // Output register: load wins, otherwise drain only on a handshake.
         if (in_xfer || scan_load) begin
            out_valid_q <= 1'b1;
            p_data_q    <= p_data_d;
         end else if (slot_free) begin
            out_valid_q <= 1'b0;
         end

         scan_done_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (en && scan_start) begin
                  state_q     <= ST_SCAN;
                  idx_q       <= IDX_FIRST;
                  scan_busy_q <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (scan_load) begin
                  if (idx_q == IDX_LAST) begin
                     state_q     <= ST_DONE;
                     scan_busy_q <= 1'b0;
                     scan_done_q <= 1'b1;
                  end else if (SCAN_DESC) begin
                     idx_q <= idx_q - 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q     <= ST_IDLE;
               scan_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.p_data    = p_data_q;
   assign scan_busy     = scan_busy_q;
   assign scan_done     = scan_done_q;

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder_3x8_seq
// Two decoder instances share all inputs: A is ascending/active-high, B is
// descending/active-low. A behavioural model tracks both every cycle.
// -----------------------------------------------------------------------------
module tb_decoder_3x8_seq;
   import decoder_3x8_seq_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       en;
   logic       scan_start;
   logic       in_valid;
   logic [2:0] p_code;
   logic       out_ready;
   logic       busy_a, done_a, busy_b, done_b;

   decoder_3x8_seq_if if_a ();
   decoder_3x8_seq_if if_b ();

   assign if_a.in_valid  = in_valid;
   assign if_a.p_code    = p_code;
   assign if_a.out_ready = out_ready;
   assign if_b.in_valid  = in_valid;
   assign if_b.p_code    = p_code;
   assign if_b.out_ready = out_ready;

   decoder_3x8_seq #(.SCAN_DESC(1'b0), .OUT_ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .scan_start(scan_start),
      .bus(if_a), .scan_busy(busy_a), .scan_done(done_a)
   );

   decoder_3x8_seq #(.SCAN_DESC(1'b1), .OUT_ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .scan_start(scan_start),
      .bus(if_b), .scan_busy(busy_b), .scan_done(done_b)
   );

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: per instance, a scan is "word number m_pos of 8".
   bit         m_desc [2] = '{1'b0, 1'b1};
   bit         m_al   [2] = '{1'b0, 1'b1};
   bit         m_vld  [2];
   logic [7:0] m_word [2];
   bit         m_busy [2];
   bit         m_done [2];
   int         m_pos  [2];

   logic [7:0] got_a[$];
   logic [7:0] got_b[$];
   logic       last_rdy_a, last_rdy_b;

   typedef struct {
      logic       iv;
      logic [2:0] code;
      logic       orr;
      logic       rdy;
      logic       vld;
      logic [7:0] data;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_word(input int code, input bit al);
      logic [7:0] w;
      w = 8'd1 << code;
      return al ? ~w : w;
   endfunction

   function automatic logic [7:0] exp_scan(input int k, input int i);
      return exp_word(m_desc[k] ? 7 - i : i, m_al[k]);
   endfunction

   function automatic bit model_rdy(input int k);
      return !m_busy[k] && !m_done[k] && en && !scan_start && (!m_vld[k] || out_ready);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_vld[k]  = 1'b0;
         m_word[k] = m_al[k] ? 8'hFF : 8'h00;
         m_busy[k] = 1'b0;
         m_done[k] = 1'b0;
         m_pos[k]  = 0;
      end
   endtask

   task automatic model_step();
      bit idle, free, load;
      int code;
      for (int k = 0; k < 2; k++) begin
         idle = !m_busy[k] && !m_done[k];
         free = !m_vld[k] || out_ready;
         load = 1'b0;
         code = 0;
         if (idle && model_rdy(k) && in_valid) begin
            load = 1'b1;
            code = int'(p_code);
         end else if (m_busy[k] && en && free) begin
            load = 1'b1;
            code = m_desc[k] ? 7 - m_pos[k] : m_pos[k];
         end
         if (load) begin
            m_vld[k]  = 1'b1;
            m_word[k] = exp_word(code, m_al[k]);
         end else if (free) begin
            m_vld[k] = 1'b0;
         end
         if (idle) begin
            if (en && scan_start) begin
               m_busy[k] = 1'b1;
               m_pos[k]  = 0;
            end
         end else if (m_busy[k]) begin
            if (load) begin
               m_pos[k]++;
               if (m_pos[k] == 8) begin
                  m_busy[k] = 1'b0;
                  m_done[k] = 1'b1;
               end
            end
         end else begin
            m_done[k] = 1'b0;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_vld_a"},  8'(if_a.out_valid), 8'(m_vld[0]));
      chk({tag, "_data_a"}, if_a.p_data,        m_word[0]);
      chk({tag, "_busy_a"}, 8'(busy_a),         8'(m_busy[0]));
      chk({tag, "_done_a"}, 8'(done_a),         8'(m_done[0]));
      chk({tag, "_vld_b"},  8'(if_b.out_valid), 8'(m_vld[1]));
      chk({tag, "_data_b"}, if_b.p_data,        m_word[1]);
      chk({tag, "_busy_b"}, 8'(busy_b),         8'(m_busy[1]));
      chk({tag, "_done_b"}, 8'(done_b),         8'(m_done[1]));
   endtask

   // One clock: drive, check in_ready, record consumed words, clock, check.
   task automatic cycle(input logic e, input logic ss, input logic iv,
                        input logic [2:0] c, input logic orr);
      en = e; scan_start = ss; in_valid = iv; p_code = c; out_ready = orr;
      #1;
      last_rdy_a = if_a.in_ready;
      last_rdy_b = if_b.in_ready;
      chk("in_ready_a", 8'(if_a.in_ready), 8'(model_rdy(0)));
      chk("in_ready_b", 8'(if_b.in_ready), 8'(model_rdy(1)));
      if (if_a.out_valid && orr) got_a.push_back(if_a.p_data);
      if (if_b.out_valid && orr) got_b.push_back(if_b.p_data);
      @(posedge clk);
      model_step();
      #1;
      check_outputs("cyc");
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
   endtask

   task automatic chk_seq(input string name, input logic [7:0] q[$], input int k);
      chk({name, "_len"}, 8'(q.size()), 8'd8);
      for (int i = 0; i < 8 && i < q.size(); i++)
         chk($sformatf("%s_w%0d", name, i), q[i], exp_scan(k, i));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int wait_n;
      rst_n = 1'b0; en = 1'b0; scan_start = 1'b0; in_valid = 1'b0;
      p_code = 3'd0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld_a",  8'(if_a.out_valid), 8'h00);
      chk("rst_data_a", if_a.p_data,        8'h00);
      chk("rst_busy_a", 8'(busy_a),         8'h00);
      chk("rst_done_a", 8'(done_a),         8'h00);
      chk("rst_vld_b",  8'(if_b.out_valid), 8'h00);
      chk("rst_data_b", if_b.p_data,        8'hFF);
      rst_n = 1'b1;

      // Pass-through and back-pressure, expectations for instance A.
      for (int i = 0; i < 8; i++)
         tbl.push_back('{1'b1, 3'(i), 1'b1, 1'b1, 1'b1, 8'h01 << i});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h80});
      tbl.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 8'h08});
      tbl.push_back('{1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 8'h08});
      tbl.push_back('{1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 8'h08});
      tbl.push_back('{1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 8'h20});
      tbl.push_back('{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h20});
      foreach (tbl[i]) begin
         cycle(1'b1, 1'b0, tbl[i].iv, tbl[i].code, tbl[i].orr);
         chk($sformatf("tbl%0d_rdy", i),  8'(last_rdy_a),     8'(tbl[i].rdy));
         chk($sformatf("tbl%0d_vld", i),  8'(if_a.out_valid), 8'(tbl[i].vld));
         chk($sformatf("tbl%0d_data", i), if_a.p_data,        tbl[i].data);
      end

      // Ascending (A) / descending active-low (B) scan.
      begin
         int nbusy, ndone;
         idle_cycles(1);
         got_a.delete(); got_b.delete();
         nbusy = 0; ndone = 0;
         cycle(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
         nbusy += int'(busy_a); ndone += int'(done_a);
         for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
            nbusy += int'(busy_a); ndone += int'(done_a);
         end
         chk("scan_busy_cycles", 8'(nbusy), 8'd8);
         chk("scan_done_pulses", 8'(ndone), 8'd1);
         chk_seq("scan_a", got_a, 0);
         chk_seq("scan_b", got_b, 1);
         cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
         chk("scan_after_rdy", 8'(last_rdy_a), 8'h01);
      end

      // Scan with an enable pause then an output stall.
      idle_cycles(1);
      got_a.delete(); got_b.delete();
      cycle(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
      idle_cycles(2);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      idle_cycles(20);
      chk_seq("pause_a", got_a, 0);
      chk_seq("pause_b", got_b, 1);

      // scan_start beats a simultaneous data transfer.
      idle_cycles(1);
      got_a.delete(); got_b.delete();
      cycle(1'b1, 1'b1, 1'b1, 3'd2, 1'b1);
      chk("prio_rdy_a", 8'(last_rdy_a), 8'h00);
      chk("prio_rdy_b", 8'(last_rdy_b), 8'h00);
      idle_cycles(20);
      chk_seq("prio_a", got_a, 0);
      chk_seq("prio_b", got_b, 1);

      // Asynchronous reset in the middle of a scan.
      idle_cycles(1);
      got_a.delete(); got_b.delete();
      cycle(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
      wait_n = 0;
      while (got_a.size() < 4 && wait_n < 20) begin
         cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
         wait_n++;
      end
      chk("midrst_reached", 8'(got_a.size()), 8'd4);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_vld_a",  8'(if_a.out_valid), 8'h00);
      chk("midrst_busy_a", 8'(busy_a),         8'h00);
      chk("midrst_data_a", if_a.p_data,        8'h00);
      chk("midrst_vld_b",  8'(if_b.out_valid), 8'h00);
      chk("midrst_busy_b", 8'(busy_b),         8'h00);
      chk("midrst_data_b", if_b.p_data,        8'hFF);
      @(posedge clk);
      #1;
      check_outputs("midrst_hold");
      rst_n = 1'b1;
      got_a.delete(); got_b.delete();
      cycle(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
      idle_cycles(20);
      chk_seq("restart_a", got_a, 0);
      chk_seq("restart_b", got_b, 1);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 9) != 0),
               ($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
